// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port GPR file with priority writes, write->read bypass,
//               pending-producer scoreboard and post-reset zero-fill sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr
);

    localparam int                c_depth = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_last  = '1;
    localparam logic [ADDR_W-1:0] c_first = ADDR_W'(1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_init_done;
    logic [DATA_W-1:0]   r_regs [c_depth];
    logic [c_depth-1:0]  r_pend;
    logic                w_run;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_cnt == c_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_cnt       <= c_first;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= (w_state_nxt == ST_RUN);
            if (r_state == ST_INIT) r_cnt <= r_cnt + c_first;
        end
    end

    assign init_done = r_init_done;
    // Outputs are forced quiet while rst is high, before the edge takes effect.
    assign w_run     = (r_state == ST_RUN) && !rst;

    // Register 0 is never written; reads of address 0 are forced to zero instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                r_regs[r_cnt] <= '0;
                r_pend[r_cnt] <= 1'b0;
            end else begin
                // Ascending loop: the highest-index port's assignment lands last.
                for (int i = 0; i < NUM_WR; i++) begin
                    if (we[i] && (waddr[i*ADDR_W +: ADDR_W] != '0)) begin
                        r_regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
                        r_pend[waddr[i*ADDR_W +: ADDR_W]] <= 1'b0;
                    end
                end
                if (set_en && (set_addr != '0)) r_pend[set_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_data;
        logic              w_hit;
        logic              w_en;

        assign w_ra = raddr[k*ADDR_W +: ADDR_W];
        assign w_en = w_run && re[k] && (w_ra != '0);

        always_comb begin
            w_data = r_regs[w_ra];
            w_hit  = 1'b0;
            for (int i = 0; i < NUM_WR; i++) begin
                if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == w_ra)) begin
                    w_hit  = 1'b1;
                    w_data = wdata[i*DATA_W +: DATA_W];
                end
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = w_en ? w_data : '0;
        assign rbusy[k]                  = w_en && r_pend[w_ra] && !w_hit;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        init_done;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        set_en;
    logic [4:0]  set_addr;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .init_done(init_done),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re       (re),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .set_en   (set_en),
        .set_addr (set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
        set_en = 1'b0; set_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        re = 2'b11; raddr[4:0] = 5'd5; raddr[9:5] = 5'd31;
        for (int c = 0; c < 31; c++) begin
            #1;
            checks++;
            if (init_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_init_done cycle %0d got %b want 0", c, init_done);
            end
            checks++;
            if (rdata !== 64'h0 || rbusy !== 2'b00) begin
                errors++;
                $display("FAIL reset_reads cycle %0d got rdata %h rbusy %b want 0/0", c, rdata, rbusy);
            end
            tick();
        end
        #1;
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_done got %b want 1", init_done);
        end
        checks++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_zero_fill got %h want 0", rdata);
        end
        idle();
    endtask

    task automatic test_bypass();
        idle();
        we[0] = 1'b1; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF;
        re = 2'b11; raddr[4:0] = 5'd5; raddr[9:5] = 5'd5;
        #1;
        checks++;
        if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL bypass got %h want deadbeefdeadbeef", rdata);
        end
        tick();
        we = '0;
        #1;
        checks++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL array_read got %h want deadbeef", rdata[31:0]);
        end
        idle();
    endtask

    task automatic test_priority();
        idle();
        we = 2'b11; waddr[4:0] = 5'd7; waddr[9:5] = 5'd7;
        wdata[31:0] = 32'h11; wdata[63:32] = 32'h22;
        re = 2'b11; raddr[4:0] = 5'd7; raddr[9:5] = 5'd7;
        #1;
        checks++;
        if (rdata !== {32'h22, 32'h22}) begin
            errors++;
            $display("FAIL prio_bypass got %h want 0000002200000022", rdata);
        end
        tick();
        we = '0;
        #1;
        checks++;
        if (rdata !== {32'h22, 32'h22}) begin
            errors++;
            $display("FAIL prio_array got %h want 0000002200000022", rdata);
        end
        idle();
    endtask

    task automatic test_r0();
        idle();
        we[0] = 1'b1; waddr[4:0] = 5'd0; wdata[31:0] = 32'hFFFFFFFF;
        re[0] = 1'b1; raddr[4:0] = 5'd0;
        #1;
        checks++;
        if (rdata[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL r0_bypass got %h want 0", rdata[31:0]);
        end
        tick();
        we = '0;
        set_en = 1'b1; set_addr = 5'd0;
        #1;
        checks++;
        if (rdata[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL r0_array got %h want 0", rdata[31:0]);
        end
        tick();
        set_en = 1'b0;
        #1;
        checks++;
        if (rbusy[0] !== 1'b0) begin
            errors++;
            $display("FAIL r0_busy got %b want 0", rbusy[0]);
        end
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        re[0] = 1'b1; raddr[4:0] = 5'd9;
        set_en = 1'b1; set_addr = 5'd9;
        #1;
        checks++;
        if (rbusy[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_before_set got %b want 0", rbusy[0]);
        end
        tick();
        set_en = 1'b0;
        #1;
        checks++;
        if (rbusy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set got %b want 1", rbusy[0]);
        end
        we[0] = 1'b1; waddr[4:0] = 5'd9; wdata[31:0] = 32'h5;
        #1;
        checks++;
        if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'h5) begin
            errors++;
            $display("FAIL sb_write_same_cycle got busy %b data %h want 0/5", rbusy[0], rdata[31:0]);
        end
        tick();
        we = '0;
        #1;
        checks++;
        if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'h5) begin
            errors++;
            $display("FAIL sb_cleared got busy %b data %h want 0/5", rbusy[0], rdata[31:0]);
        end
        set_en = 1'b1; set_addr = 5'd9;
        we[1] = 1'b1; waddr[9:5] = 5'd9; wdata[63:32] = 32'h6;
        tick();
        idle();
        re[0] = 1'b1; raddr[4:0] = 5'd9;
        #1;
        checks++;
        if (rbusy[0] !== 1'b1 || rdata[31:0] !== 32'h6) begin
            errors++;
            $display("FAIL sb_set_wins got busy %b data %h want 1/6", rbusy[0], rdata[31:0]);
        end
        idle();
    endtask

    task automatic test_rst_mid();
        idle();
        we[0] = 1'b1; waddr[4:0] = 5'd3; wdata[31:0] = 32'hA5;
        tick();
        idle();
        set_en = 1'b1; set_addr = 5'd4;
        tick();
        idle();
        re = 2'b11; raddr[4:0] = 5'd3; raddr[9:5] = 5'd4;
        #1;
        checks++;
        if (rdata[31:0] !== 32'hA5 || rbusy[1] !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got data %h busy %b want a5/1", rdata[31:0], rbusy[1]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rdata !== 64'h0 || rbusy !== 2'b00) begin
            errors++;
            $display("FAIL mid_during_rst got %h/%b want 0/0", rdata, rbusy);
        end
        tick();
        rst = 1'b0;
        // Writes and pending marks held throughout the sweep must be dropped.
        we[0] = 1'b1; waddr[4:0] = 5'd3; wdata[31:0] = 32'h77;
        set_en = 1'b1; set_addr = 5'd4;
        #1;
        checks++;
        if (init_done !== 1'b0 || rdata !== 64'h0) begin
            errors++;
            $display("FAIL mid_init got done %b data %h want 0/0", init_done, rdata);
        end
        for (int c = 0; c < 31; c++) tick();
        idle();
        re = 2'b11; raddr[4:0] = 5'd3; raddr[9:5] = 5'd4;
        #1;
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL mid_done got %b want 1", init_done);
        end
        checks++;
        if (rdata[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL mid_r3_cleared got %h want 0", rdata[31:0]);
        end
        checks++;
        if (rbusy[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_r4_busy got %b want 0", rbusy[1]);
        end
        raddr[4:0] = 5'd5; raddr[9:5] = 5'd9;
        #1;
        checks++;
        if (rdata !== 64'h0 || rbusy !== 2'b00) begin
            errors++;
            $display("FAIL mid_other_cleared got %h/%b want 0/0", rdata, rbusy);
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_bypass();
        test_priority();
        test_r0();
        test_scoreboard();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
